// File: rtl/spi_regfile_pkg.sv
// Shared types and default widths for the SPI register-file slice.
// Also used by the SPI slave bridge for its address and data widths.
package spi_regfile_pkg;

   localparam int ADDR_WIDTH_DEF = 7;
   localparam int DATA_WIDTH_DEF = 8;

   typedef enum logic {
      IDLE,
      LOCKED
   } arb_state_e;

   typedef enum logic {
      TAG_S,
      TAG_C
   } port_tag_e;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin grant with a last-grant pointer; force_s makes the
// next contested arbitration favour port S.
module rr_arbiter_2
   import spi_regfile_pkg::*;
(
   input  logic clk_i,
   input  logic rst_ni,
   input  logic req_s,
   input  logic req_c,
   input  logic en_s,
   input  logic force_s,
   output logic gnt_s,
   output logic gnt_c
);

   port_tag_e last_q;
   logic      req_s_ok;

   assign req_s_ok = req_s & en_s;
   assign gnt_s    = req_s_ok & (~req_c | (last_q == TAG_C));
   assign gnt_c    = req_c & ~gnt_s;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         last_q <= TAG_C;
      end else if (force_s) begin
         last_q <= TAG_C;
      end else if (gnt_s) begin
         last_q <= TAG_S;
      end else if (gnt_c) begin
         last_q <= TAG_C;
      end
   end

endmodule

// File: rtl/spi_regfile_arbiter.sv
// Shares one single-port register memory between port S and port C, with a
// port C lock and timeout. Define SPI_ARB_WPROT_EN to block S writes >= PROT_BASE.
//
// state  | meaning
// IDLE   | round-robin between S and C
// LOCKED | only C is granted; lock counter runs toward LOCK_MAX-1
module spi_regfile_arbiter
   import spi_regfile_pkg::*;
#(
   parameter int                    ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int                    DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int                    LOCK_MAX   = 16,
   parameter logic [ADDR_WIDTH-1:0] PROT_BASE  = 'h60
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  s_req_i,
   input  logic                  s_we_i,
   input  logic [ADDR_WIDTH-1:0] s_addr_i,
   input  logic [DATA_WIDTH-1:0] s_wdata_i,
   output logic                  s_gnt_o,
   output logic                  s_rvalid_o,
   output logic [DATA_WIDTH-1:0] s_rdata_o,
   input  logic                  c_req_i,
   input  logic                  c_we_i,
   input  logic [ADDR_WIDTH-1:0] c_addr_i,
   input  logic [DATA_WIDTH-1:0] c_wdata_i,
   input  logic                  c_lock_i,
   output logic                  c_gnt_o,
   output logic                  c_rvalid_o,
   output logic [DATA_WIDTH-1:0] c_rdata_o,
   output logic                  mem_en_o,
   output logic                  mem_we_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic [DATA_WIDTH-1:0] mem_wdata_o,
   input  logic [DATA_WIDTH-1:0] mem_rdata_i,
   output logic                  lock_to_o,
   output logic                  wp_err_o
);

   localparam int              CNT_W    = (LOCK_MAX > 2) ? $clog2(LOCK_MAX) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_MAX - 1);

   arb_state_e            state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  armed_q, armed_d;
   logic                  gnt_s, gnt_c, wp_hit, timeout;
   logic                  pend_q;
   port_tag_e             tag_q;
   logic [DATA_WIDTH-1:0] s_rdata_q, c_rdata_q;

   rr_arbiter_2 u_rr (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .req_s   (s_req_i),
      .req_c   (c_req_i),
      .en_s    (state_q == IDLE),
      .force_s (timeout),
      .gnt_s   (gnt_s),
      .gnt_c   (gnt_c)
   );

`ifdef SPI_ARB_WPROT_EN
   assign wp_hit = gnt_s & s_we_i & (s_addr_i >= PROT_BASE);
`else
   assign wp_hit = 1'b0;
`endif

   assign s_gnt_o   = gnt_s;
   assign c_gnt_o   = gnt_c;
   assign wp_err_o  = wp_hit;
   assign timeout   = (state_q == LOCKED) & c_lock_i & (cnt_q == CNT_LAST);
   assign lock_to_o = timeout;

   always_comb begin
      mem_en_o    = 1'b0;
      mem_we_o    = 1'b0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      if (gnt_s) begin
         mem_en_o    = ~wp_hit;
         mem_we_o    = s_we_i & ~wp_hit;
         mem_addr_o  = s_addr_i;
         mem_wdata_o = s_wdata_i;
      end else if (gnt_c) begin
         mem_en_o    = 1'b1;
         mem_we_o    = c_we_i;
         mem_addr_o  = c_addr_i;
         mem_wdata_o = c_wdata_i;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      armed_d = armed_q;
      // after a timeout the lock only re-arms once c_lock_i has been seen low
      if (timeout) begin
         armed_d = 1'b0;
      end else if (!c_lock_i) begin
         armed_d = 1'b1;
      end
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (gnt_c && c_lock_i && armed_q) begin
               state_d = LOCKED;
            end
         end
         LOCKED: begin
            if (!c_lock_i || timeout) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         armed_q <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         armed_q <= armed_d;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pend_q    <= 1'b0;
         tag_q     <= TAG_S;
         s_rdata_q <= '0;
         c_rdata_q <= '0;
      end else begin
         pend_q <= (gnt_s & ~s_we_i) | (gnt_c & ~c_we_i);
         if (gnt_s) begin
            tag_q <= TAG_S;
         end else if (gnt_c) begin
            tag_q <= TAG_C;
         end
         if (s_rvalid_o) begin
            s_rdata_q <= mem_rdata_i;
         end
         if (c_rvalid_o) begin
            c_rdata_q <= mem_rdata_i;
         end
      end
   end

   // read data is forwarded in the response cycle and held afterwards
   assign s_rvalid_o = pend_q & (tag_q == TAG_S);
   assign c_rvalid_o = pend_q & (tag_q == TAG_C);
   assign s_rdata_o  = s_rvalid_o ? mem_rdata_i : s_rdata_q;
   assign c_rdata_o  = c_rvalid_o ? mem_rdata_i : c_rdata_q;

endmodule

// File: tb/tb_spi_regfile_arbiter.sv
// Bench for spi_regfile_arbiter: directed scenarios plus randomized traffic
// against a cycle-level reference model and a behavioural memory.
module tb_spi_regfile_arbiter;

   localparam int        LOCK_MAX = 16;
   localparam logic [6:0] PROT    = 7'h60;
`ifdef SPI_ARB_WPROT_EN
   localparam bit WPROT = 1'b1;
`else
   localparam bit WPROT = 1'b0;
`endif

   logic       clk_i = 1'b0;
   logic       rst_ni = 1'b0;
   logic       s_req_i = 0, s_we_i = 0, c_req_i = 0, c_we_i = 0, c_lock_i = 0;
   logic [6:0] s_addr_i = 0, c_addr_i = 0;
   logic [7:0] s_wdata_i = 0, c_wdata_i = 0;
   logic       s_gnt_o, s_rvalid_o, c_gnt_o, c_rvalid_o;
   logic [7:0] s_rdata_o, c_rdata_o;
   logic       mem_en_o, mem_we_o, lock_to_o, wp_err_o;
   logic [6:0] mem_addr_o;
   logic [7:0] mem_wdata_o;
   logic [7:0] mem_rdata_i = 0;

   spi_regfile_arbiter #(.LOCK_MAX(LOCK_MAX)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .s_req_i(s_req_i), .s_we_i(s_we_i), .s_addr_i(s_addr_i), .s_wdata_i(s_wdata_i),
      .s_gnt_o(s_gnt_o), .s_rvalid_o(s_rvalid_o), .s_rdata_o(s_rdata_o),
      .c_req_i(c_req_i), .c_we_i(c_we_i), .c_addr_i(c_addr_i), .c_wdata_i(c_wdata_i),
      .c_lock_i(c_lock_i),
      .c_gnt_o(c_gnt_o), .c_rvalid_o(c_rvalid_o), .c_rdata_o(c_rdata_o),
      .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
      .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
      .lock_to_o(lock_to_o), .wp_err_o(wp_err_o)
   );

   always #5 clk_i = ~clk_i;

   logic [7:0] mem [128];
   logic [7:0] ref_mem [128];

   always @(posedge clk_i) begin
      if (mem_en_o) begin
         if (mem_we_o) mem[mem_addr_o] <= mem_wdata_o;
         else          mem_rdata_i     <= mem[mem_addr_o];
      end
   end

   int n_err = 0;
   int n_chk = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // reference model state
   bit         m_last_c, m_locked, m_armed, m_rv_s, m_rv_c, m_gs, m_gc;
   int         m_cnt;
   logic [7:0] m_rd_s, m_rd_c;
   logic       seen_s_gnt, seen_c_gnt, seen_lock_to, seen_wp, seen_mem_en, seen_s_rv, seen_c_rv;
   logic [7:0] seen_s_rd, seen_c_rd;

   task automatic model_reset();
      m_last_c = 1; m_locked = 0; m_armed = 1; m_cnt = 0;
      m_rv_s = 0; m_rv_c = 0; m_rd_s = 0; m_rd_c = 0; m_gs = 0; m_gc = 0;
   endtask

   // called at posedge+1 with inputs driven; checks mid-cycle, returns at next posedge+1
   task automatic step();
      bit gs, gc, to, wp;
      #4;
      gs = s_req_i && !m_locked && (!c_req_i || m_last_c);
      gc = c_req_i && !gs;
      to = m_locked && c_lock_i && (m_cnt == LOCK_MAX - 1);
      wp = WPROT && gs && s_we_i && (s_addr_i >= PROT);
      seen_s_gnt = s_gnt_o; seen_c_gnt = c_gnt_o; seen_lock_to = lock_to_o; seen_wp = wp_err_o;
      seen_mem_en = mem_en_o; seen_s_rv = s_rvalid_o; seen_c_rv = c_rvalid_o;
      seen_s_rd = s_rdata_o; seen_c_rd = c_rdata_o;
      check_val("s_gnt", s_gnt_o, gs);
      check_val("c_gnt", c_gnt_o, gc);
      check_val("mem_en", mem_en_o, (gs && !wp) || gc);
      check_val("mem_we", mem_we_o, (gs && !wp && s_we_i) || (gc && c_we_i));
      if (gs || gc) check_val("mem_addr", mem_addr_o, gs ? s_addr_i : c_addr_i);
      if ((gs && !wp && s_we_i) || (gc && c_we_i))
         check_val("mem_wdata", mem_wdata_o, gs ? s_wdata_i : c_wdata_i);
      check_val("lock_to", lock_to_o, to);
      check_val("wp_err", wp_err_o, wp);
      check_val("s_rvalid", s_rvalid_o, m_rv_s);
      check_val("c_rvalid", c_rvalid_o, m_rv_c);
      check_val("s_rdata", s_rdata_o, m_rd_s);
      check_val("c_rdata", c_rdata_o, m_rd_c);
      m_rv_s = gs && !s_we_i;
      m_rv_c = gc && !c_we_i;
      if (m_rv_s) m_rd_s = ref_mem[s_addr_i];
      if (m_rv_c) m_rd_c = ref_mem[c_addr_i];
      if (gs && s_we_i && !wp) ref_mem[s_addr_i] = s_wdata_i;
      if (gc && c_we_i) ref_mem[c_addr_i] = c_wdata_i;
      if (gs) m_last_c = 0;
      if (gc) m_last_c = 1;
      if (to) m_last_c = 1;
      if (!m_locked) begin
         if (gc && c_lock_i && m_armed) begin m_locked = 1; m_cnt = 0; end
      end else if (!c_lock_i || to) begin
         m_locked = 0; m_cnt = 0;
      end else begin
         m_cnt++;
      end
      if (to) m_armed = 0;
      else if (!c_lock_i) m_armed = 1;
      m_gs = gs; m_gc = gc;
      @(posedge clk_i); #1;
   endtask

   task automatic do_reset();
      rst_ni = 0;
      s_req_i = 0; s_we_i = 0; c_req_i = 0; c_we_i = 0; c_lock_i = 0;
      #2;
      check_val("rst_ctl", {s_gnt_o, s_rvalid_o, c_gnt_o, c_rvalid_o, mem_en_o, mem_we_o,
                            lock_to_o, wp_err_o}, 0);
      check_val("rst_data", {s_rdata_o, c_rdata_o, mem_addr_o, mem_wdata_o}, 0);
      repeat (2) @(posedge clk_i);
      #1;
      rst_ni = 1;
      model_reset();
   endtask

   function automatic logic [6:0] rand_addr();
      if ($urandom_range(0, 1) == 1) return 7'($urandom_range(8'h58, 8'h67));
      return 7'($urandom_range(0, 127));
   endfunction

   logic [7:0] old_val;
   int         lock_mode;

   initial begin
      for (int i = 0; i < 128; i++) begin
         mem[i] = 8'($urandom);
         ref_mem[i] = mem[i];
      end
      mem[5] = 8'hA5; ref_mem[5] = 8'hA5;
      @(posedge clk_i); #1;
      do_reset();

      // single S read
      s_req_i = 1; s_we_i = 0; s_addr_i = 7'h05;
      step();
      check_val("a_gnt", seen_s_gnt, 1);
      s_req_i = 0;
      step();
      check_val("a_rvalid", seen_s_rv, 1);
      check_val("a_rdata", seen_s_rd, 8'hA5);

      // contested reads alternate S,C,...
      do_reset();
      s_req_i = 1; s_we_i = 0; s_addr_i = 7'h10;
      c_req_i = 1; c_we_i = 0; c_addr_i = 7'h20;
      for (int i = 0; i < 6; i++) begin
         step();
         check_val("b_alt_s", seen_s_gnt, (i % 2) == 0);
      end
      s_req_i = 0; c_req_i = 0;
      step();
      check_val("b_last_rv_c", seen_c_rv, 1);

      // voluntary lock
      do_reset();
      c_req_i = 1; c_we_i = 1; c_addr_i = 7'h30; c_wdata_i = 8'h5A; c_lock_i = 1;
      step();
      check_val("c_lock_gnt", seen_c_gnt, 1);
      c_req_i = 0; s_req_i = 1; s_we_i = 0; s_addr_i = 7'h30;
      for (int i = 0; i < 4; i++) begin
         step();
         check_val("c_s_blocked", seen_s_gnt, 0);
      end
      c_lock_i = 0;
      step();
      check_val("c_s_blocked_rel", seen_s_gnt, 0);
      step();
      check_val("c_s_after_rel", seen_s_gnt, 1);
      s_req_i = 0;
      step();
      check_val("c_rdata_locked_wr", seen_s_rd, 8'h5A);

      // lock timeout and re-arm
      do_reset();
      c_req_i = 1; c_we_i = 1; c_addr_i = 7'h31; c_wdata_i = 8'h11; c_lock_i = 1;
      step();
      c_req_i = 0; s_req_i = 1; s_we_i = 0; s_addr_i = 7'h31;
      for (int k = 1; k <= LOCK_MAX; k++) begin
         step();
         check_val("d_s_blocked", seen_s_gnt, 0);
         check_val("d_lock_to", seen_lock_to, k == LOCK_MAX);
      end
      c_req_i = 1;
      step();
      check_val("d_s_after_to", seen_s_gnt, 1);
      s_req_i = 0;
      step();
      check_val("d_c_gnt_unarmed", seen_c_gnt, 1);
      c_req_i = 0; s_req_i = 1;
      step();
      check_val("d_not_relocked", seen_s_gnt, 1);
      s_req_i = 0; c_lock_i = 0;
      step();
      c_lock_i = 1; c_req_i = 1;
      step();
      c_req_i = 0; s_req_i = 1;
      step();
      check_val("d_relocked", seen_s_gnt, 0);
      c_lock_i = 0;
      step();
      step();
      check_val("d_s_after_rearm", seen_s_gnt, 1);
      s_req_i = 0;
      step();

      // reset during a read grant drops the response
      do_reset();
      s_req_i = 1; s_we_i = 0; s_addr_i = 7'h05;
      #4;
      check_val("e_gnt", s_gnt_o, 1);
      do_reset();
      step();
      check_val("e_no_rvalid", seen_s_rv, 0);
      check_val("e_rdata", seen_s_rd, 0);

      // write protection
      do_reset();
      old_val = ref_mem[7'h61];
      s_req_i = 1; s_we_i = 1; s_addr_i = 7'h61; s_wdata_i = 8'hFF;
      step();
      check_val("f_gnt", seen_s_gnt, 1);
      check_val("f_wp_err", seen_wp, WPROT);
      check_val("f_mem_en", seen_mem_en, !WPROT);
      s_req_i = 0; c_req_i = 1; c_we_i = 0; c_addr_i = 7'h61;
      step();
      c_req_i = 0;
      step();
      check_val("f_readback", seen_c_rd, WPROT ? old_val : 8'hFF);

      // randomized traffic
      do_reset();
      lock_mode = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if (cyc % 50 == 0) lock_mode = $urandom_range(0, 2);
         if (!s_req_i || m_gs) begin
            s_req_i = ($urandom_range(0, 9) < 6);
            s_we_i = 1'($urandom_range(0, 1));
            s_addr_i = rand_addr();
            s_wdata_i = 8'($urandom);
         end
         if (!c_req_i || m_gc) begin
            c_req_i = ($urandom_range(0, 9) < 5);
            c_we_i = 1'($urandom_range(0, 1));
            c_addr_i = rand_addr();
            c_wdata_i = 8'($urandom);
         end
         case (lock_mode)
            0: c_lock_i = 0;
            1: c_lock_i = ($urandom_range(0, 3) != 0);
            default: c_lock_i = 1;
         endcase
         step();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/spi_regfile_arbiter.md
Name: spi_regfile_arbiter

Overview:
- Shares one single-port register memory between two requesters: port S (SPI-side bridge, already in the clk domain) and port C (on-chip core).
- Round-robin arbitration grants at most one access per cycle and routes each 1-cycle read response back to the port that issued it.
- Port C can lock the memory for atomic read-modify-write sequences; a lock timeout bounds how long port S can be starved.

Parameters:
- ADDR_WIDTH, 7, memory address width.
- DATA_WIDTH, 8, memory word width.
- LOCK_MAX, 16, maximum number of cycles in LOCKED before a forced release; must be at least 2.
- PROT_BASE, 7'h60, first SPI-write-protected address; used only when SPI_ARB_WPROT_EN is defined.

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  asynchronous reset, active low
- s_req_i  in  1  port S request; held until granted
- s_we_i  in  1  port S write (1) or read (0)
- s_addr_i  in  ADDR_WIDTH  port S address
- s_wdata_i  in  DATA_WIDTH  port S write data
- s_gnt_o  out  1  port S grant; combinational, same cycle as the memory access
- s_rvalid_o  out  1  port S read data valid, one-cycle pulse
- s_rdata_o  out  DATA_WIDTH  port S read data; holds its value until the next port S read
- c_req_i, c_we_i, c_addr_i, c_wdata_i  in  1/1/ADDR_WIDTH/DATA_WIDTH  port C request, same semantics as port S
- c_lock_i  in  1  port C lock request
- c_gnt_o, c_rvalid_o, c_rdata_o  out  1/1/DATA_WIDTH  port C response, same semantics as port S
- mem_en_o  out  1  memory access enable
- mem_we_o  out  1  memory write enable
- mem_addr_o  out  ADDR_WIDTH  memory address
- mem_wdata_o  out  DATA_WIDTH  memory write data
- mem_rdata_i  in  DATA_WIDTH  memory read data, valid one cycle after a read with mem_en_o=1
- lock_to_o  out  1  lock-timeout pulse, one cycle
- wp_err_o  out  1  write-protect violation pulse, one cycle

Behaviour:
- Reset values:
  - All outputs 0.
  - FSM in IDLE.
  - Round-robin pointer favours S.
  - Lock counter 0.
  - Pending read tag cleared; an in-flight read response is dropped.
- Request/grant rules:
  - A request is accepted in the cycle its gnt is 1.
  - A requester must hold req, we, addr and wdata stable until granted.
  - mem_* outputs are a combinational mux of the granted port. With no grant: mem_en_o=0 and mem_we_o=0.
- IDLE:
  - Only one port requests: grant it.
  - Both request: grant the port opposite the pointer's last grant.
  - The pointer updates on every grant.
  - A port C grant with c_lock_i=1 moves the FSM to LOCKED next cycle.
- LOCKED:
  - Only port C is granted; s_gnt_o=0.
  - The lock counter increments every cycle in LOCKED.
  - c_lock_i=0 in any cycle: return to IDLE next cycle; the counter clears. A port C grant in that same cycle is still served.
  - Counter reaches LOCK_MAX-1: forced return to IDLE, lock_to_o pulses, and the next arbitration favours S.
  - After a timeout, c_lock_i is ignored until it has been seen low for at least 1 cycle (lock re-arm flag).
- Read path:
  - A read grant sets the tag (S or C) and a pending bit.
  - Next cycle: the tagged port's rvalid=1 and its rdata register loads mem_rdata_i.
  - Back-to-back reads are supported: a new read can be granted in the cycle the previous response returns.
- Write path: writes produce no rvalid.
- Read-during-write: same-cycle collisions are impossible (single grant). Write-then-read of the same address on consecutive cycles returns the new data, which is the memory's responsibility.
- Throughput: one access per cycle. A waiting S request is granted within 2 cycles in IDLE, or within LOCK_MAX+1 cycles if the memory is locked.

Optional Feature:
- Macro: SPI_ARB_WPROT_EN.
- Defined: a port S write with s_addr_i >= PROT_BASE is granted (s_gnt_o=1) but mem_en_o=0, wp_err_o pulses, and the pointer updates as for a normal grant. Port C is never protected.
- Undefined: no check; wp_err_o is tied to 0 and PROT_BASE is unused.

Decomposition:
- Shared package spi_regfile_pkg holds:
  - the FSM state enum {IDLE, LOCKED};
  - the port tag enum {TAG_S, TAG_C};
  - default ADDR_WIDTH and DATA_WIDTH constants, also used by the SPI slave bridge.
- One natural sub-module: rr_arbiter_2, the 2-way round-robin grant logic with pointer, reused elsewhere.

Test Plan:
- Reset, then s_req_i=1, read, addr 7'h05, memory holds 8'hA5 -> s_gnt_o=1 in cycle 0; s_rvalid_o=1 with s_rdata_o=8'hA5 in cycle 1.
- S and C both request every cycle for 6 cycles -> grants alternate S,C,S,C,S,C; each rvalid routed to the correct port.
- C locks: granted write with c_lock_i=1, then holds lock 4 cycles while S requests -> s_gnt_o=0 throughout; S granted in the first cycle after c_lock_i falls.
- C holds c_lock_i=1 permanently with LOCK_MAX=16 -> lock_to_o pulses after 16 locked cycles; S granted next cycle; C not re-locked until c_lock_i toggles low.
- rst_ni asserted in the cycle a read is granted -> no rvalid after reset deassertion; all outputs 0.
- With SPI_ARB_WPROT_EN: S writes 8'hFF to 7'h61 -> s_gnt_o=1, mem_en_o=0, wp_err_o=1; a later C read of 7'h61 returns the old value.
